// File: rtl/render_queue.sv
// Avalon-MM slave FIFO of 48-bit render instructions feeding vga_display.
// Software stages the low word, then pushes; the display side pops from a show-ahead head.
module render_queue #(
  parameter int unsigned DEPTH           = 64,
  parameter logic [7:0]  DO_RENDER_MAGIC = 8'hFF
) (
  input  logic        clk50,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [1:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [47:0] render_queue_dout,
  input  logic        render_queue_pop_front,
  output logic        queue_empty,
  output logic        queue_full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);
  localparam logic [47:0]   EmptyFill = {DO_RENDER_MAGIC, 40'h0};

  logic [47:0]   r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [15:0]   r_frames;
  logic [31:0]   r_stage_lo;
  logic [31:0]   r_readdata;
  logic          r_ovf;
  logic          r_unf;

  logic          w_wr_en;
  logic          w_rd_en;
  logic          w_push_req;
  logic          w_flush;
  logic          w_clr_sticky;
  logic          w_pop_ok;
  logic          w_push_ok;
  logic          w_unf_set;
  logic          w_ovf_set;
  logic          w_frame_inc;
  logic          w_frame_dec;
  logic [47:0]   w_entry;
  logic [47:0]   w_head;
  logic [11:0]   w_count12;
  logic [31:0]   w_status;
  logic [CW-1:0] w_count_nxt;
  logic [15:0]   w_frames_nxt;
  logic [31:0]   w_readdata_nxt;

  assign w_wr_en      = chipselect & write;
  assign w_rd_en      = chipselect & read;
  assign w_push_req   = w_wr_en && (address == 2'd1);
  assign w_flush      = w_wr_en && (address == 2'd2) && writedata[0];
  assign w_clr_sticky = w_wr_en && (address == 2'd2) && writedata[1];
  assign w_entry      = {writedata[15:0], r_stage_lo};
  assign w_head       = r_mem[r_rd_ptr];

  assign queue_empty  = (r_count == '0);
  assign queue_full   = (r_count == FullCount);

  // Pop is resolved first so a full queue can accept a push in the same cycle.
  assign w_pop_ok     = render_queue_pop_front && !queue_empty && !w_flush;
  assign w_unf_set    = render_queue_pop_front && queue_empty && !w_flush;
  assign w_push_ok    = w_push_req && (!queue_full || w_pop_ok);
  assign w_ovf_set    = w_push_req && !w_push_ok;

  assign w_frame_inc  = w_push_ok && (writedata[15:8] == DO_RENDER_MAGIC);
  assign w_frame_dec  = w_pop_ok && (w_head[47:40] == DO_RENDER_MAGIC);

  assign render_queue_dout = queue_empty ? EmptyFill : w_head;

  assign w_count12 = 12'(r_count);
  assign w_status  = {16'h0, w_count12, r_ovf, r_unf, queue_full, queue_empty};
  assign readdata  = r_readdata;

  always_comb begin
    w_count_nxt = r_count;
    if (w_flush) begin
      w_count_nxt = '0;
    end else if (w_push_ok && !w_pop_ok) begin
      w_count_nxt = r_count + CW'(1);
    end else if (w_pop_ok && !w_push_ok) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  // Frame counter saturates at both ends; simultaneous inc and dec cancel.
  always_comb begin
    w_frames_nxt = r_frames;
    if (w_flush) begin
      w_frames_nxt = '0;
    end else if (w_frame_inc && !w_frame_dec && (r_frames != 16'hFFFF)) begin
      w_frames_nxt = r_frames + 16'd1;
    end else if (w_frame_dec && !w_frame_inc && (r_frames != 16'h0000)) begin
      w_frames_nxt = r_frames - 16'd1;
    end
  end

  always_comb begin
    w_readdata_nxt = r_readdata;
    if (w_rd_en) begin
      case (address)
        2'd0:    w_readdata_nxt = w_status;
        2'd1:    w_readdata_nxt = {16'h0, r_frames};
        2'd2:    w_readdata_nxt = {8'h0, render_queue_dout[47:24]};
        default: w_readdata_nxt = {8'h0, render_queue_dout[23:0]};
      endcase
    end
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_frames   <= '0;
      r_stage_lo <= '0;
      r_readdata <= '0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_frames   <= w_frames_nxt;
      r_readdata <= w_readdata_nxt;
      // A same-cycle set wins over the software clear.
      r_ovf      <= (r_ovf & ~w_clr_sticky) | w_ovf_set;
      r_unf      <= (r_unf & ~w_clr_sticky) | w_unf_set;
      if (w_wr_en && (address == 2'd0)) begin
        r_stage_lo <= writedata;
      end
      if (w_flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_pop_ok) begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
        end
        if (w_push_ok) begin
          r_wr_ptr <= r_wr_ptr + PW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk50) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

endmodule

// File: tb/tb_render_queue.sv
// Scoreboarded bench for render_queue: reads queue expected readdata, a monitor compares it.
`timescale 1ns/1ps
module tb_render_queue;
  localparam int unsigned D    = 64;
  localparam logic [47:0] FILL = 48'hFF00_0000_0000;

  logic        clk50 = 1'b0;
  logic        reset = 1'b0;
  logic        chipselect = 1'b0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [1:0]  address = 2'd0;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;
  logic [47:0] render_queue_dout;
  logic        render_queue_pop_front = 1'b0;
  logic        queue_empty;
  logic        queue_full;

  render_queue #(.DEPTH(D), .DO_RENDER_MAGIC(8'hFF)) dut (
    .clk50                  (clk50),
    .reset                  (reset),
    .chipselect             (chipselect),
    .write                  (write),
    .read                   (read),
    .address                (address),
    .writedata              (writedata),
    .readdata               (readdata),
    .render_queue_dout      (render_queue_dout),
    .render_queue_pop_front (render_queue_pop_front),
    .queue_empty            (queue_empty),
    .queue_full             (queue_full)
  );

  always #10 clk50 = ~clk50;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [47:0] model_q[$];
  logic        rd_pend = 1'b0;

  always @(posedge clk50) rd_pend <= chipselect && read;

  always @(negedge clk50) begin : monitor
    logic [31:0] e;
    string       nm;
    if (rd_pend) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_read: readdata=%h with nothing expected", readdata);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (readdata !== e) begin
          n_errors++;
          $display("FAIL %s: readdata=%h expected=%h", nm, readdata, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    exp_q.push_back(exp);
    name_q.push_back(name);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge clk50);
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk50);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic push(input logic [47:0] e);
    wr(2'd0, e[31:0]);
    wr(2'd1, {16'h0, e[47:32]});
    if (model_q.size() < D) model_q.push_back(e);
  endtask

  task automatic pop();
    render_queue_pop_front = 1'b1;
    @(negedge clk50);
    render_queue_pop_front = 1'b0;
    if (model_q.size() > 0) void'(model_q.pop_front());
  endtask

  task automatic push_pop(input logic [47:0] e);
    wr(2'd0, e[31:0]);
    chipselect = 1'b1; write = 1'b1; address = 2'd1; writedata = {16'h0, e[47:32]};
    render_queue_pop_front = 1'b1;
    @(negedge clk50);
    chipselect = 1'b0; write = 1'b0; render_queue_pop_front = 1'b0;
    if (model_q.size() > 0) void'(model_q.pop_front());
    if (model_q.size() < D) model_q.push_back(e);
  endtask

  task automatic chk_head(input string name);
    logic [47:0] h;
    h = (model_q.size() > 0) ? model_q[0] : FILL;
    rd(2'd2, {8'h0, h[47:24]}, {name, "_hi"});
    rd(2'd3, {8'h0, h[23:0]}, {name, "_lo"});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b1;
    repeat (3) @(negedge clk50);
    reset = 1'b0;
    @(negedge clk50);

    // Out of reset
    chk("t1_empty", queue_empty, 1);
    chk("t1_full", queue_full, 0);
    chk("t1_dout", render_queue_dout, FILL);
    chk("t1_readdata", readdata, 0);
    rd(2'd0, 32'h0000_0001, "t1_status");
    rd(2'd1, 32'h0000_0000, "t1_frames");

    // Single entry via staged write
    wr(2'd0, 32'h0064_3201);
    wr(2'd1, 32'h0000_0102);
    model_q.push_back(48'h0102_0064_3201);
    chk("t2_dout", render_queue_dout, 48'h0102_0064_3201);
    rd(2'd0, 32'h0000_0010, "t2_status");
    rd(2'd2, 32'h0001_0200, "t2_head_hi");
    rd(2'd3, 32'h0064_3201, "t2_head_lo");
    pop();
    chk("t2_empty", queue_empty, 1);
    rd(2'd0, 32'h0000_0001, "t2_status_after_pop");

    // Three sprites plus an end-of-frame marker
    push(48'h11_0010_0020_01);
    push(48'h22_0030_0040_02);
    push(48'h33_0050_0060_03);
    wr(2'd0, 32'h0);
    wr(2'd1, 32'h0000_FF00);
    model_q.push_back(48'hFF_0000_0000_00);
    rd(2'd1, 32'h0000_0001, "t3_frames");
    rd(2'd0, 32'h0000_0040, "t3_status");
    for (int i = 0; i < 3; i++) begin
      chk_head("t3_order");
      pop();
    end
    rd(2'd1, 32'h0000_0001, "t3_frames_before_marker_pop");
    chk_head("t3_marker");
    pop();
    rd(2'd1, 32'h0000_0000, "t3_frames_after");
    rd(2'd0, 32'h0000_0001, "t3_status_after");

    // Overflow, then push+pop while full
    for (int i = 0; i <= D; i++) push({8'h10, 16'(i), 16'(i * 3), 8'h5A});
    chk("t4_full", queue_full, 1);
    rd(2'd0, 32'h0000_040A, "t4_status");
    push_pop(48'hFF_ABCD_1234_77);
    rd(2'd0, 32'h0000_040A, "t4_status_pushpop");
    rd(2'd1, 32'h0000_0001, "t4_frames");
    for (int i = 0; i < D; i++) begin
      chk_head("t4_drain");
      pop();
    end
    rd(2'd0, 32'h0000_0009, "t4_status_drained");
    rd(2'd1, 32'h0000_0000, "t4_frames_drained");

    // Underflow, sticky clear, empty push+pop, flush
    pop();
    rd(2'd0, 32'h0000_000D, "t5_unf");
    wr(2'd2, 32'h2);
    rd(2'd0, 32'h0000_0001, "t5_cleared");
    push_pop(48'h20_0001_0002_03);
    rd(2'd0, 32'h0000_0014, "t5_empty_pushpop");
    chk("t5_dout", render_queue_dout, 48'h20_0001_0002_03);
    wr(2'd2, 32'h2);
    push(48'hFF_0000_0000_00);
    push(48'h30_0004_0005_06);
    push(48'hFF_0000_0000_00);
    push(48'h31_0007_0008_09);
    rd(2'd1, 32'h0000_0002, "t5_frames");
    rd(2'd0, 32'h0000_0050, "t5_status5");
    wr(2'd2, 32'h1);
    model_q.delete();
    rd(2'd0, 32'h0000_0001, "t5_flush_status");
    rd(2'd1, 32'h0000_0000, "t5_flush_frames");
    chk("t5_flush_dout", render_queue_dout, FILL);

    // Mid-operation reset
    for (int i = 0; i < 10; i++) push({8'h40, 16'(i), 16'h0, 8'h00});
    rd(2'd0, 32'h0000_00A0, "t6_status10");
    reset = 1'b1;
    @(posedge clk50);
    #1;
    chk("t6_empty", queue_empty, 1);
    chk("t6_dout", render_queue_dout, FILL);
    chk("t6_readdata", readdata, 0);
    @(negedge clk50);
    reset = 1'b0;
    model_q.delete();
    @(negedge clk50);
    rd(2'd0, 32'h0000_0001, "t6_status_after_reset");

    // Pointer wrap-around
    push(48'h50_1111_2222_01);
    push(48'h50_3333_4444_02);
    for (int i = 0; i < 2 * D; i++) begin
      push({8'h60, 16'(i), 16'(i ^ 16'h00F0), 8'(i)});
      chk_head("t6_wrap");
      pop();
    end
    rd(2'd0, 32'h0000_0020, "t6_wrap_status");

    repeat (2) @(negedge clk50);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL pending_reads: %0d expected reads never returned", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
